// File: rtl/addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package addsub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fourBitRCA.sv
// Purely combinational 4-bit ripple-carry adder slice.
module fourBitRCA (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};

endmodule

// File: rtl/addsub_serial_ctrl.sv
// Nibble-serial W-bit add/subtract around one fourBitRCA slice, valid/ready on both sides.
// Optional macro ADDSUB_OVF_EN enables the registered signed-overflow flag (Ovf tied to 0 otherwise).
module addsub_serial_ctrl
  import addsub_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic                      Op,
  input  logic [NIBBLE_W*WORDS-1:0] A,
  input  logic [NIBBLE_W*WORDS-1:0] B,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic [NIBBLE_W*WORDS-1:0] Result,
  output logic                      Cout,
  output logic                      Ovf
);

  localparam int W     = NIBBLE_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic             carry;
  logic [W-1:0]     result_reg;
  logic             cout_reg;
  logic             last;
  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic [3:0]       slice_sum;
  logic             slice_cout;

  assign last    = (idx == IDX_LAST);
  assign slice_a = a_reg[NIBBLE_W*idx +: NIBBLE_W];
  assign slice_b = b_reg[NIBBLE_W*idx +: NIBBLE_W];

  fourBitRCA u_slice (
    .A    (slice_a),
    .B    (slice_b),
    .Cin  (carry),
    .Sum  (slice_sum),
    .Cout (slice_cout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; no accept is possible outside IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (InValid) next_state = RUN;    else next_state = IDLE;
      RUN:     if (last)    next_state = DONE;   else next_state = RUN;
      DONE:    if (OutReady) next_state = IDLE;  else next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  // Operand capture and one-nibble-per-cycle datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      carry      <= 1'b0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (InValid) begin
            a_reg <= A;
            b_reg <= (Op == OP_SUB) ? ~B : B;
            carry <= Op;
            idx   <= '0;
          end
        end
        RUN: begin
          result_reg[NIBBLE_W*idx +: NIBBLE_W] <= slice_sum;
          carry <= slice_cout;
          if (last) begin
            cout_reg <= slice_cout;
            idx      <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef ADDSUB_OVF_EN
  logic ovf_reg;

  // Signed overflow: like-signed operands producing a result of the other sign.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (state == RUN && last) begin
      ovf_reg <= (a_reg[W-1] == b_reg[W-1]) && (slice_sum[3] != a_reg[W-1]);
    end
  end

  assign Ovf = ovf_reg;
`else
  assign Ovf = 1'b0;
`endif

  assign InReady  = (state == IDLE);
  assign OutValid = (state == DONE);
  assign Result   = result_reg;
  assign Cout     = cout_reg;

endmodule

// File: doc/addsub_serial_ctrl.md
# addsub_serial_ctrl

Sequencer that performs WORDS-nibble (4·WORDS-bit) addition or subtraction by time-multiplexing a single 4-bit ripple-carry slice (`fourBitRCA`), one nibble per clock, LSB nibble first. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. Subtraction is two's complement: B is inverted and the initial carry is 1.

## Interface
- WORDS, 4, number of nibbles per operand (≥1); operand width W = 4·WORDS
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- InValid  in  1  operand request valid
- InReady  out  1  block can accept an operation (high only in IDLE)
- Op  in  1  0 = A+B, 1 = A−B; sampled on accept
- A  in  W  operand A; sampled on accept
- B  in  W  operand B; sampled on accept
- OutValid  out  1  Result/Cout/Ovf valid
- OutReady  in  1  consumer accepts the result
- Result  out  W  sum or difference modulo 2^W
- Cout  out  1  carry out of the MSB nibble (for subtract: 1 = no borrow)
- Ovf  out  1  signed two's-complement overflow

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: InReady=1. On InValid&&InReady, capture A, Op, and B (inverted when Op=1); set carry register = Op; idx=0; → RUN.
- RUN: slice inputs are A[4·idx+:4], B'[4·idx+:4], carry. Each cycle, write Sum into Result[4·idx+:4] and Cout into the carry register; idx++. On idx==WORDS−1: latch Cout; compute Ovf = (A[W−1]==B'[W−1]) && (Sum[3]!=A[W−1]); → DONE.
- DONE: OutValid=1. Result/Cout/Ovf are held stable until OutReady=1; then → IDLE. InReady=0 in DONE, so a new operation is never accepted in the handoff cycle.
- InValid in RUN/DONE is ignored (no accept). Op/A/B changes after the accept edge have no effect.
- Result nibbles update progressively during RUN. They are meaningful only while OutValid=1.
- idx counter width is max(1, $clog2(WORDS)). WORDS=1 takes one RUN cycle.
- Reset mid-RUN or mid-DONE aborts the operation: → IDLE, no OutValid pulse, partial result discarded.

## Timing
- Reset values: InReady=1, OutValid=0, Result=0, Cout=0, Ovf=0, state IDLE, idx=0, carry=0.
- Accept edge at cycle 0. OutValid rises after edge WORDS, i.e. a latency of WORDS cycles.
- Minimum issue period is WORDS+2 cycles (RUN ×WORDS, DONE ≥1, IDLE 1).
- InReady and OutValid are decoded from the registered state only; there is no combinational in→out path.
- Critical path: nibble mux → 4-bit ripple chain → Result/carry registers.

## Configuration
- ADDSUB_OVF_EN defined: Ovf computed as above and registered at the last RUN cycle.
- Not defined: the Ovf port exists but is tied to 0, and the overflow logic is removed.

## Structure
- Package addsub_pkg:
  - NIBBLE_W=4
  - state enum {IDLE, RUN, DONE}
  - Op encodings OP_ADD=0, OP_SUB=1
- Sub-module: one instance of the existing 4-bit slice `fourBitRCA` (A, B, Cin, Sum, Cout). The controller holds all registers; the slice stays purely combinational.

## Test plan
WORDS=4 unless stated; ADDSUB_OVF_EN defined.
- Add, no carry: 0x1234+0x0FFF, Op=0 → Result=0x2233, Cout=0, Ovf=0; OutValid rises exactly 4 cycles after accept.
- Carry ripple across all nibbles: 0xFFFF+0x0001 → Result=0x0000, Cout=1, Ovf=0.
- Subtract with borrow: 0x0005−0x0007, Op=1 → Result=0xFFFE, Cout=0, Ovf=0. Subtract with no borrow: 0x0007−0x0005 → Result=0x0002, Cout=1.
- Signed overflow: 0x7FFF+0x0001 → Result=0x8000, Ovf=1. 0x8000−0x0001 → Result=0x7FFF, Ovf=1. Without the macro, Ovf=0 for both.
- Backpressure: hold OutReady=0 for 5 cycles in DONE with InValid=1 → OutValid and Result stay stable, InReady=0, and no second accept occurs. Release → IDLE next cycle, then accept.
- Reset mid-RUN (assert rst at idx=2) → immediately InReady=1, OutValid=0, Result=0. No OutValid appears for the aborted operation; a subsequent 0x0001+0x0001 gives 0x0002. Also run WORDS=1 with 0xF+0x1 → Result=0x0, Cout=1 after 1 cycle.
